// File: rtl/control_step_sequencer_if.sv
// Control/status bundle between the picoRISC step sequencer and its environment.
// The sequencer is the slave; whatever drives run/fc_cpu/branch requests is the master.
interface control_step_sequencer_if;
  logic         run;
  logic         fc_cpu;
  logic         one_byte;
  logic         br_req;
  logic [7:0]   br_tgt;
  logic         end_instr;
  logic         irq;
  logic         halt;
  logic [255:0] T;
  logic [7:0]   step;
  logic         busy;
  logic         waiting;
  logic         trap;
  logic         halted;

  modport master (
    output run, fc_cpu, one_byte, br_req, br_tgt, end_instr, irq, halt,
    input  T, step, busy, waiting, trap, halted
  );

  modport slave (
    input  run, fc_cpu, one_byte, br_req, br_tgt, end_instr, irq, halt,
    output T, step, busy, waiting, trap, halted
  );
endinterface

// File: rtl/control_step_sequencer.sv
// Hardwired control-unit step generator: owns step counter CNT and the one-hot
// step vector T consumed by the operational-signal decoder.
module control_step_sequencer #(
  parameter int unsigned LAST_STEP = 56,
  parameter int unsigned IRQ_STEP  = 43,
  parameter int unsigned TRAP_STEP = 255,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  control_step_sequencer_if.slave     bus
);

  localparam logic [7:0] LAST       = 8'(LAST_STEP);
  localparam logic [7:0] IRQ        = 8'(IRQ_STEP);
  localparam logic [7:0] TRAP       = 8'(TRAP_STEP);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    CLS_IDLE,
    CLS_TRAP,
    CLS_WAIT,
    CLS_RUN
  } step_class_e;

  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        trap_q, trap_d;
  logic        halted_q, halted_d;
  logic [7:0]  seq_next;
  logic        set_halt;
  logic        is_wait_step;
  logic        tgt_illegal;
  step_class_e cls;

  // Memory read steps 2,6,17,47,54 and write steps 24,44,51 stall on fc_cpu.
  always_comb begin
    case (cnt_q)
      8'd2, 8'd6, 8'd17, 8'd47, 8'd54, 8'd24, 8'd44, 8'd51: is_wait_step = 1'b1;
      default:                                             is_wait_step = 1'b0;
    endcase
  end

  always_comb begin
    if (cnt_q == TRAP)                    cls = CLS_TRAP;
    else if (cnt_q == 8'd0)               cls = CLS_IDLE;
    else if (is_wait_step && !bus.fc_cpu) cls = CLS_WAIT;
    else                                  cls = CLS_RUN;
  end

  assign tgt_illegal = (bus.br_tgt == 8'd0) || (bus.br_tgt == 8'd4) || (bus.br_tgt > LAST);

  // Successor of a step that is allowed to advance this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    seq_next = 8'(cnt_q + 8'd1);
    set_halt = 1'b0;
    if (bus.end_instr) begin
      if (bus.halt) begin
        seq_next = 8'd0;
        set_halt = 1'b1;
      end else if (bus.irq) begin
        seq_next = IRQ;
      end else begin
        seq_next = 8'd1;
      end
    end else if (bus.br_req) begin
      seq_next = tgt_illegal ? TRAP : bus.br_tgt;
    end else if (cnt_q == 8'd3) begin
      seq_next = bus.one_byte ? 8'd8 : 8'd5;
    end else if (cnt_q == 8'd4 || cnt_q >= LAST) begin
      seq_next = TRAP;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    halted_d = halted_q;
    unique case (cls)
      CLS_TRAP: ;
      CLS_IDLE: begin
        if (bus.run) begin
          cnt_d    = 8'd1;
          halted_d = 1'b0;
        end
      end
      CLS_WAIT: begin
        if (wcnt_q >= WAIT_LIMIT) cnt_d  = TRAP;
        else                      wcnt_d = 8'(wcnt_q + 8'd1);
      end
      CLS_RUN: begin
        cnt_d = seq_next;
        if (set_halt) halted_d = 1'b1;
      end
    endcase
    if (cnt_d != cnt_q) wcnt_d = 8'd0;
    trap_d = trap_q | (cnt_d == TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 8'd0;
      wcnt_q   <= 8'd0;
      trap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      trap_q   <= trap_d;
      halted_q <= halted_d;
    end
  end

  assign bus.T       = 256'd1 << cnt_q;
  assign bus.step    = cnt_q;
  assign bus.busy    = (cnt_q != 8'd0) && (cnt_q != TRAP);
  assign bus.waiting = is_wait_step && !bus.fc_cpu;
  assign bus.trap    = trap_q;
  assign bus.halted  = halted_q;

endmodule
